// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a show-ahead FIFO with framing-error pulse and sticky overflow.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_AW      = 3
) (
    input  logic               i_Clock,
    input  logic               i_Rst_n,
    input  logic               i_Rx_Serial,
    input  logic               i_Rd_En,
    input  logic               i_Clr_Err,
    output logic [7:0]         o_Rd_Byte,
    output logic               o_Rd_Valid,
    output logic [FIFO_AW:0]   o_Fifo_Count,
    output logic               o_Frame_Err,
    output logic               o_Overflow
);
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {HUNT, IDLE, START, DATA, STOP} state_t;

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_sync_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [7:0]           shift_q, shift_d;
    logic                 push_q, push_d;
    logic                 ferr_q, ferr_d;
    logic                 ovf_q, ovf_d;
    logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]     count_q, count_d;
    logic [7:0]           mem_q [DEPTH];
    logic                 pop, full, wr, drop;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        push_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            HUNT: begin
                cnt_d   = '0;
                state_d = rx_sync_q ? IDLE : HUNT;
            end
            IDLE: begin
                cnt_d   = '0;
                state_d = rx_sync_q ? IDLE : START;
            end
            START: if (cnt_q == HALF) begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = rx_sync_q ? IDLE : DATA;
            end
            DATA: if (cnt_q == LAST) begin
                cnt_d          = '0;
                shift_d[idx_q] = rx_sync_q;
                idx_d          = idx_q + 3'd1;
                state_d        = (idx_q == 3'd7) ? STOP : DATA;
            end
            STOP: if (cnt_q == LAST) begin
                cnt_d   = '0;
                push_d  = rx_sync_q;
                ferr_d  = ~rx_sync_q;
                state_d = rx_sync_q ? IDLE : HUNT;
            end
            default: state_d = HUNT;
        endcase
    end

    // A full FIFO still accepts a push when the head is popped in the same cycle.
    assign pop     = i_Rd_En & o_Rd_Valid;
    assign full    = count_q == (FIFO_AW+1)'(DEPTH);
    assign wr      = push_q & (~full | pop);
    assign drop    = push_q & full & ~pop;
    assign count_d = count_q + (FIFO_AW+1)'(wr) - (FIFO_AW+1)'(pop);
    assign ovf_d   = drop ? 1'b1 : (i_Clr_Err ? 1'b0 : ovf_q);

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= HUNT;
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            push_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= i_Rx_Serial;
            rx_sync_q <= rx_meta_q;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            push_q    <= push_d;
            ferr_q    <= ferr_d;
            ovf_q     <= ovf_d;
            wr_ptr_q  <= wr_ptr_q + FIFO_AW'(wr);
            rd_ptr_q  <= rd_ptr_q + FIFO_AW'(pop);
            count_q   <= count_d;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (wr) mem_q[wr_ptr_q] <= shift_q;
    end

    assign o_Rd_Valid   = count_q != '0;
    assign o_Rd_Byte    = o_Rd_Valid ? mem_q[rd_ptr_q] : 8'h00;
    assign o_Fifo_Count = count_q;
    assign o_Frame_Err  = ferr_q;
    assign o_Overflow   = ovf_q;
endmodule
